// File: rtl/fsm_trace_rle_pkg.sv
// Shared constants, record layout and encoder state type for the FSM output
// run-length trace encoder.
package fsm_trace_rle_pkg;

  localparam int OUT_W_DEF = 19;
  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_DEF = 16;

  // Record layout for the default widths: {mark, run_len, value}, mark in the MSB.
  localparam int VAL_LSB  = 0;
  localparam int LEN_LSB  = OUT_W_DEF;
  localparam int MARK_BIT = OUT_W_DEF + CNT_W_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int rec_width(input int out_w, input int cnt_w);
    return 1 + cnt_w + out_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through synchronous FIFO. Pointers carry one extra wrap bit
// so that full and empty can be told apart.
module trace_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    fill     = wr_ptr_q - rd_ptr_q;
    dout     = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity and
  // dout is forced to zero while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fsm_trace_rle.sv
// Run-length encoder for a traced FSM output word: each record is
// {mark, run_len, value}, queued in a FWFT FIFO for a valid/ready reader.
module fsm_trace_rle
  import fsm_trace_rle_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [OUT_W-1:0]         out_word,
  input  logic                     fsm_rst,
  input  logic                     flush,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [CNT_W+OUT_W:0]     rec_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow
);

  localparam int REC_W = rec_width(OUT_W, CNT_W);
  localparam logic [CNT_W-1:0] MAX_LEN = '1;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] cur_val_q, cur_val_d;
  logic [CNT_W-1:0] cur_len_q, cur_len_d;
  logic             cur_mark_q, cur_mark_d;
  logic             overflow_q, overflow_d;
  logic             emit, pop, full, empty;
  logic [REC_W-1:0] emit_rec;

  assign pop       = rec_valid && rec_ready;
  assign rec_valid = !empty;
  assign overflow  = overflow_q;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no latch is
    // inferred on paths that leave it unassigned.
    state_d    = state_q;
    cur_val_d  = cur_val_q;
    cur_len_d  = cur_len_q;
    cur_mark_d = cur_mark_q;
    emit       = 1'b0;
    emit_rec   = {cur_mark_q, cur_len_q, cur_val_q};

    if (sample_en) begin
      if (state_q == RUN && !flush && out_word == cur_val_q &&
          fsm_rst == cur_mark_q && cur_len_q != MAX_LEN) begin
        cur_len_d = cur_len_q + CNT_W'(1);
      end else begin
        // Value/mark change, saturation or flush closes the open run (if any)
        // and this sample starts the next one.
        emit       = (state_q == RUN);
        state_d    = RUN;
        cur_val_d  = out_word;
        cur_len_d  = CNT_W'(1);
        cur_mark_d = fsm_rst;
      end
    end else if (flush && state_q == RUN) begin
      emit    = 1'b1;
      state_d = IDLE;
    end

    overflow_d = overflow_q | (emit && full && !pop);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_val_q  <= '0;
      cur_len_q  <= '0;
      cur_mark_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_val_q  <= cur_val_d;
      cur_len_q  <= cur_len_d;
      cur_mark_q <= cur_mark_d;
      overflow_q <= overflow_d;
    end
  end

  trace_fifo #(
    .WIDTH(REC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (emit),
    .pop   (pop),
    .din   (emit_rec),
    .dout  (rec_data),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

endmodule

// File: tb/tb_fsm_trace_rle.sv
// Directed self-checking bench for fsm_trace_rle with default parameters.
module tb_fsm_trace_rle;

  localparam int OUT_W = 19;
  localparam int CNT_W = 8;
  localparam int DEPTH = 16;
  localparam int REC_W = 1 + CNT_W + OUT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_en = 1'b0;
  logic [OUT_W-1:0] out_word = '0;
  logic             fsm_rst = 1'b0;
  logic             flush = 1'b0;
  logic             rec_valid;
  logic             rec_ready = 1'b0;
  logic [REC_W-1:0] rec_data;
  logic [4:0]       fill;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [REC_W-1:0] got_q [$];

  fsm_trace_rle #(.OUT_W(OUT_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .out_word  (out_word),
    .fsm_rst   (fsm_rst),
    .flush     (flush),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .fill      (fill),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Inputs only change 1 time unit after a rising edge, so the falling edge
  // sees exactly what the next rising edge will pop.
  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) got_q.push_back(rec_data);
  end

  function automatic logic [REC_W-1:0] mk(input logic m, input int len, input logic [OUT_W-1:0] v);
    return {m, CNT_W'(len), v};
  endfunction

  function automatic logic [REC_W-1:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sample(input logic [OUT_W-1:0] v, input logic m);
    sample_en = 1'b1; out_word = v; fsm_rst = m;
    step();
    sample_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_en = 1'b0; flush = 1'b0; rec_ready = 1'b0;
    out_word = '0; fsm_rst = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    got_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rec_valid); end
    n_checks++; if (rec_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", rec_data); end
    n_checks++; if (fill !== 5'd0) begin n_fail++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_basic_runs();
    do_reset();
    rec_ready = 1'b1;
    repeat (3) do_sample(19'h00005, 1'b0);
    do_sample(19'h00007, 1'b0);
    do_flush();
    repeat (3) step();
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL basic_count got=%0d exp=2", got_q.size()); end
    n_checks++; if (got_at(0) !== mk(1'b0, 3, 19'h00005)) begin n_fail++; $display("FAIL basic_rec0 got=%h exp=%h", got_at(0), mk(1'b0, 3, 19'h00005)); end
    n_checks++; if (got_at(1) !== mk(1'b0, 1, 19'h00007)) begin n_fail++; $display("FAIL basic_rec1 got=%h exp=%h", got_at(1), mk(1'b0, 1, 19'h00007)); end
    n_checks++; if (fill !== 5'd0) begin n_fail++; $display("FAIL basic_fill got=%0d exp=0", fill); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow got=%b exp=0", overflow); end
    n_checks++; if (rec_data !== '0) begin n_fail++; $display("FAIL basic_empty_data got=%h exp=0", rec_data); end
  endtask

  task automatic test_saturation();
    do_reset();
    rec_ready = 1'b1;
    repeat (300) do_sample(19'h1ABCD, 1'b0);
    do_flush();
    repeat (3) step();
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL sat_count got=%0d exp=2", got_q.size()); end
    n_checks++; if (got_at(0) !== mk(1'b0, 255, 19'h1ABCD)) begin n_fail++; $display("FAIL sat_rec0 got=%h exp=%h", got_at(0), mk(1'b0, 255, 19'h1ABCD)); end
    n_checks++; if (got_at(1) !== mk(1'b0, 45, 19'h1ABCD)) begin n_fail++; $display("FAIL sat_rec1 got=%h exp=%h", got_at(1), mk(1'b0, 45, 19'h1ABCD)); end
  endtask

  task automatic test_mark_change();
    do_reset();
    rec_ready = 1'b1;
    repeat (2) do_sample(19'h0, 1'b1);
    repeat (2) do_sample(19'h0, 1'b0);
    do_flush();
    repeat (3) step();
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL mark_count got=%0d exp=2", got_q.size()); end
    n_checks++; if (got_at(0) !== mk(1'b1, 2, 19'h0)) begin n_fail++; $display("FAIL mark_rec0 got=%h exp=%h", got_at(0), mk(1'b1, 2, 19'h0)); end
    n_checks++; if (got_at(1) !== mk(1'b0, 2, 19'h0)) begin n_fail++; $display("FAIL mark_rec1 got=%h exp=%h", got_at(1), mk(1'b0, 2, 19'h0)); end
    n_checks++; if (fill !== 5'd0) begin n_fail++; $display("FAIL mark_fill got=%0d exp=0", fill); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      do_sample(19'h100 + 19'(i), 1'b0);
      if (i == 16) begin
        n_checks++; if (fill !== 5'd16) begin n_fail++; $display("FAIL ovf_fill16 got=%0d exp=16", fill); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before got=%b exp=0", overflow); end
      end
    end
    n_checks++; if (fill !== 5'd16) begin n_fail++; $display("FAIL ovf_fill17 got=%0d exp=16", fill); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    rec_ready = 1'b1;
    repeat (20) step();
    n_checks++; if (got_q.size() != 16) begin n_fail++; $display("FAIL ovf_drain_count got=%0d exp=16", got_q.size()); end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (got_at(k) !== mk(1'b0, 1, 19'h100 + 19'(k))) begin
        n_fail++; $display("FAIL ovf_rec%0d got=%h exp=%h", k, got_at(k), mk(1'b0, 1, 19'h100 + 19'(k)));
      end
    end
    n_checks++; if (fill !== 5'd0) begin n_fail++; $display("FAIL ovf_drain_fill got=%0d exp=0", fill); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 17; i++) do_sample(19'h100 + 19'(i), 1'b0);
    n_checks++; if (fill !== 5'd16) begin n_fail++; $display("FAIL b2b_full got=%0d exp=16", fill); end
    rec_ready = 1'b1;
    do_sample(19'h200, 1'b0);
    n_checks++; if (fill !== 5'd16) begin n_fail++; $display("FAIL b2b_fill got=%0d exp=16", fill); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
    repeat (20) step();
    n_checks++; if (got_q.size() != 17) begin n_fail++; $display("FAIL b2b_count got=%0d exp=17", got_q.size()); end
    n_checks++; if (got_at(0) !== mk(1'b0, 1, 19'h100)) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", got_at(0), mk(1'b0, 1, 19'h100)); end
    n_checks++; if (got_at(16) !== mk(1'b0, 1, 19'h110)) begin n_fail++; $display("FAIL b2b_last got=%h exp=%h", got_at(16), mk(1'b0, 1, 19'h110)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    do_sample(19'h00011, 1'b0);
    do_sample(19'h00022, 1'b0);
    do_sample(19'h00033, 1'b0);
    do_sample(19'h00044, 1'b0);
    do_sample(19'h00044, 1'b0);
    n_checks++; if (fill !== 5'd3) begin n_fail++; $display("FAIL arst_queued got=%0d exp=3", fill); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", rec_valid); end
    n_checks++; if (fill !== 5'd0) begin n_fail++; $display("FAIL arst_fill got=%0d exp=0", fill); end
    step();
    rst = 1'b0;
    step();
    got_q.delete();
    rec_ready = 1'b1;
    do_sample(19'h00044, 1'b0);
    do_flush();
    repeat (3) step();
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL arst_count got=%0d exp=1", got_q.size()); end
    n_checks++; if (got_at(0) !== mk(1'b0, 1, 19'h00044)) begin n_fail++; $display("FAIL arst_fresh got=%h exp=%h", got_at(0), mk(1'b0, 1, 19'h00044)); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL arst_overflow got=%b exp=0", overflow); end
  endtask

  initial begin
    test_reset();
    test_basic_runs();
    test_saturation();
    test_mark_change();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
